// File: rtl/mindy_join.sv
// mindy_join: joins one meta-data beat with FRAME_BEATS frame-data beats per
// frame onto a single AXI-Stream output held in one register stage.
// Optional feature macro: MINDY_JOIN_FRAME_COUNT_EN (enables frame_count;
// when undefined, frame_count is tied to 0).
module mindy_join #(
   parameter int DATA_WBITS  = 512,
   parameter int FRAME_BEATS = 64
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WBITS-1:0] AXIS_MD_IN_TDATA,
   input  logic                  AXIS_MD_IN_TVALID,
   output logic                  AXIS_MD_IN_TREADY,
   input  logic [DATA_WBITS-1:0] AXIS_FD_IN_TDATA,
   input  logic                  AXIS_FD_IN_TVALID,
   output logic                  AXIS_FD_IN_TREADY,
   output logic [DATA_WBITS-1:0] AXIS_OUT_TDATA,
   output logic                  AXIS_OUT_TVALID,
   output logic                  AXIS_OUT_TLAST,
   input  logic                  AXIS_OUT_TREADY,
   output logic [31:0]           frame_count
);

   localparam int CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BEATS - 1);

   typedef enum logic {S_MD = 1'b0, S_FD = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WBITS-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;

   logic loadable;
   logic md_hs;
   logic fd_hs;
   logic last_beat;

   // Output register may take a new beat when empty or being drained this cycle.
   // Readies are held low while reset is asserted.
   assign loadable          = ~tvalid_q | AXIS_OUT_TREADY;
   assign AXIS_MD_IN_TREADY = resetn & loadable & (state_q == S_MD);
   assign AXIS_FD_IN_TREADY = resetn & loadable & (state_q == S_FD);
   assign md_hs             = AXIS_MD_IN_TREADY & AXIS_MD_IN_TVALID;
   assign fd_hs             = AXIS_FD_IN_TREADY & AXIS_FD_IN_TVALID;
   assign last_beat         = (cnt_q == LAST_IDX);

   assign AXIS_OUT_TDATA  = tdata_q;
   assign AXIS_OUT_TVALID = tvalid_q;
   assign AXIS_OUT_TLAST  = tlast_q;

   // Next-state: select which stream loads the output register and track beats.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      if (loadable) begin
         tvalid_d = 1'b0;
      end
      if (md_hs) begin
         tdata_d  = AXIS_MD_IN_TDATA;
         tvalid_d = 1'b1;
         tlast_d  = 1'b0;
         cnt_d    = '0;
         state_d  = S_FD;
      end else if (fd_hs) begin
         tdata_d  = AXIS_FD_IN_TDATA;
         tvalid_d = 1'b1;
         if (last_beat) begin
            tlast_d = 1'b1;
            cnt_d   = '0;
            state_d = S_MD;
         end else begin
            tlast_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   // State, beat counter and output register; reset discards any pending beat.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_MD;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

`ifdef MINDY_JOIN_FRAME_COUNT_EN
   logic [31:0] fcnt_q, fcnt_d;
   logic        frame_done;

   assign frame_done  = fd_hs & last_beat;
   assign fcnt_d      = frame_done ? (fcnt_q + 32'd1) : fcnt_q;
   assign frame_count = fcnt_q;

   // Count frames as their last beat enters the output register; wraps naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fcnt_q <= 32'd0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end
`else
   assign frame_count = 32'd0;
`endif

endmodule

// File: tb/tb_mindy_join.sv
// Testbench for mindy_join: directed vector table, hand-written corner
// sequences, a randomized scoreboard run and a FRAME_BEATS=1 instance.
module tb_mindy_join;

   localparam int W = 512;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;

   // FRAME_BEATS=4 instance signals
   logic [W-1:0] md_d = '0, fd_d = '0, o_d;
   logic         md_v = 1'b0, fd_v = 1'b0, o_r = 1'b0;
   logic         md_r, fd_r, o_v, o_l;
   logic [31:0]  fc;

   // FRAME_BEATS=1 instance signals
   logic [W-1:0] q_md_d = '0, q_fd_d = '0, q_o_d;
   logic         q_md_v = 1'b0, q_fd_v = 1'b0, q_o_r = 1'b0;
   logic         q_md_r, q_fd_r, q_o_v, q_o_l;
   logic [31:0]  q_fc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mindy_join #(.DATA_WBITS(W), .FRAME_BEATS(4)) dut (
      .clk(clk), .resetn(rstn),
      .AXIS_MD_IN_TDATA(md_d), .AXIS_MD_IN_TVALID(md_v), .AXIS_MD_IN_TREADY(md_r),
      .AXIS_FD_IN_TDATA(fd_d), .AXIS_FD_IN_TVALID(fd_v), .AXIS_FD_IN_TREADY(fd_r),
      .AXIS_OUT_TDATA(o_d), .AXIS_OUT_TVALID(o_v), .AXIS_OUT_TLAST(o_l),
      .AXIS_OUT_TREADY(o_r), .frame_count(fc)
   );

   mindy_join #(.DATA_WBITS(W), .FRAME_BEATS(1)) dut1 (
      .clk(clk), .resetn(rstn),
      .AXIS_MD_IN_TDATA(q_md_d), .AXIS_MD_IN_TVALID(q_md_v), .AXIS_MD_IN_TREADY(q_md_r),
      .AXIS_FD_IN_TDATA(q_fd_d), .AXIS_FD_IN_TVALID(q_fd_v), .AXIS_FD_IN_TREADY(q_fd_r),
      .AXIS_OUT_TDATA(q_o_d), .AXIS_OUT_TVALID(q_o_v), .AXIS_OUT_TLAST(q_o_l),
      .AXIS_OUT_TREADY(q_o_r), .frame_count(q_fc)
   );

   function automatic logic [31:0] fcx(input int n);
`ifdef MINDY_JOIN_FRAME_COUNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      md_v = 1'b0; fd_v = 1'b0; o_r = 1'b0;
      q_md_v = 1'b0; q_fd_v = 1'b0; q_o_r = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " out_valid"}, o_v, 0);
      chk({tag, " out_last"}, o_l, 0);
      chk({tag, " out_data"}, o_d, 0);
      chk({tag, " frame_count"}, fc, 0);
      chk({tag, " md_ready"}, md_r, 0);
      chk({tag, " fd_ready"}, fd_r, 0);
      chk({tag, " fb1 out_valid"}, q_o_v, 0);
      chk({tag, " fb1 md_ready"}, q_md_r, 0);
      chk({tag, " fb1 fd_ready"}, q_fd_r, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      idle_inputs();
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // One accepted beat on the chosen stream with the output drained every cycle.
   task automatic xfer(input bit is_md, input logic [31:0] val, input bit exp_last, input string nm);
      @(negedge clk);
      md_v = is_md;  md_d = W'(val);
      fd_v = !is_md; fd_d = W'(val);
      o_r  = 1'b1;
      #1;
      if (is_md) chk({nm, " md_ready"}, md_r, 1);
      else       chk({nm, " fd_ready"}, fd_r, 1);
      @(posedge clk); #1;
      chk({nm, " out_valid"}, o_v, 1);
      chk({nm, " out_data"}, o_d, W'(val));
      chk({nm, " out_last"}, o_l, exp_last);
      md_v = 1'b0; fd_v = 1'b0;
   endtask

   function automatic logic [W-1:0] md_val(input int f);
      return W'(32'hAA000 + f);
   endfunction

   function automatic logic [W-1:0] fd_val(input int i);
      return W'(32'h10000 + i);
   endfunction

   function automatic logic [W-1:0] ref_beat(input int j);
      int f, p;
      f = j / 5;
      p = j % 5;
      if (p == 0) return md_val(f);
      return fd_val(f * 4 + p - 1);
   endfunction

   typedef struct {
      bit          mv;
      logic [31:0] md;
      bit          fv;
      logic [31:0] fd;
      bit          ordy;
      bit          e_mr;
      bit          e_fr;
      bit          e_ov;
      logic [31:0] e_od;
      bit          e_ol;
   } vec_t;

   vec_t tbl [11];

   initial begin
      bit mhs, fhs, ohs;
      int mi, fi, oj, nlast, cyc;

      //              mv  md     fv  fd     ordy mr fr ov od      ol
      tbl[0]  = '{1'b0, 32'h0,  1'b1, 32'h1,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0};
      tbl[1]  = '{1'b1, 32'hA0, 1'b1, 32'h1,  1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b0};
      tbl[2]  = '{1'b1, 32'hB0, 1'b1, 32'h1,  1'b1, 1'b0, 1'b1, 1'b1, 32'h1,  1'b0};
      tbl[3]  = '{1'b1, 32'hB0, 1'b1, 32'h2,  1'b1, 1'b0, 1'b1, 1'b1, 32'h2,  1'b0};
      tbl[4]  = '{1'b1, 32'hB0, 1'b1, 32'h3,  1'b1, 1'b0, 1'b1, 1'b1, 32'h3,  1'b0};
      tbl[5]  = '{1'b1, 32'hB0, 1'b1, 32'h4,  1'b1, 1'b0, 1'b1, 1'b1, 32'h4,  1'b1};
      tbl[6]  = '{1'b1, 32'hB0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4,  1'b1};
      tbl[7]  = '{1'b1, 32'hB0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB0, 1'b0};
      tbl[8]  = '{1'b0, 32'h0,  1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,  1'b0, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
      tbl[10] = '{1'b0, 32'h0,  1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0};

      // Reset held from time 0
      idle_inputs();
      #2;
      check_reset_outputs("init");
      do_reset();

      // FRAME_BEATS=1: 3 frames, 6 beats, TLAST on every FD beat
      @(negedge clk);
      q_md_v = 1'b1; q_md_d = W'(32'h100);
      q_fd_v = 1'b1; q_fd_d = W'(32'h200);
      q_o_r  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk($sformatf("fb1 beat%0d valid", i), q_o_v, 1);
         chk($sformatf("fb1 beat%0d data", i), q_o_d,
             (i % 2 == 0) ? W'(32'h100 + i / 2) : W'(32'h200 + i / 2));
         chk($sformatf("fb1 beat%0d last", i), q_o_l, (i % 2 == 1));
         @(negedge clk);
         if (i % 2 == 0) q_md_d = W'(32'h100 + i / 2 + 1);
         else            q_fd_d = W'(32'h200 + i / 2 + 1);
         if (i == 5) begin q_md_v = 1'b0; q_fd_v = 1'b0; end
      end
      #1;
      chk("fb1 frame_count", q_fc, fcx(3));

      // Directed vector table
      do_reset();
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         md_v = tbl[i].mv; md_d = W'(tbl[i].md);
         fd_v = tbl[i].fv; fd_d = W'(tbl[i].fd);
         o_r  = tbl[i].ordy;
         #1;
         chk($sformatf("v%0d md_ready", i), md_r, tbl[i].e_mr);
         chk($sformatf("v%0d fd_ready", i), fd_r, tbl[i].e_fr);
         @(posedge clk); #1;
         chk($sformatf("v%0d out_valid", i), o_v, tbl[i].e_ov);
         if (tbl[i].e_ov) begin
            chk($sformatf("v%0d out_data", i), o_d, W'(tbl[i].e_od));
            chk($sformatf("v%0d out_last", i), o_l, tbl[i].e_ol);
         end
      end
      chk("table frame_count", fc, fcx(1));

      // Output back-pressure for 10 clocks after the first beat
      do_reset();
      xfer(1'b1, 32'hA0, 1'b0, "stall md");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         md_v = 1'b1; md_d = W'(32'hEE);
         fd_v = 1'b1; fd_d = W'(32'h1);
         o_r  = 1'b0;
         #1;
         chk($sformatf("stall%0d md_ready", i), md_r, 0);
         chk($sformatf("stall%0d fd_ready", i), fd_r, 0);
         @(posedge clk); #1;
         chk($sformatf("stall%0d out_valid", i), o_v, 1);
         chk($sformatf("stall%0d out_data", i), o_d, W'(32'hA0));
      end
      xfer(1'b0, 32'h1, 1'b0, "stall fd1");
      xfer(1'b0, 32'h2, 1'b0, "stall fd2");
      xfer(1'b0, 32'h3, 1'b0, "stall fd3");
      xfer(1'b0, 32'h4, 1'b1, "stall fd4");
      chk("stall frame_count", fc, fcx(1));

      // Reset asserted mid-frame
      do_reset();
      xfer(1'b1, 32'hA0, 1'b0, "rst f0 md");
      for (int i = 1; i <= 4; i++) xfer(1'b0, 32'(i), (i == 4), $sformatf("rst f0 fd%0d", i));
      chk("rst pre frame_count", fc, fcx(1));
      xfer(1'b1, 32'hB0, 1'b0, "rst f1 md");
      xfer(1'b0, 32'h5, 1'b0, "rst f1 fd1");
      xfer(1'b0, 32'h6, 1'b0, "rst f1 fd2");
      @(negedge clk);
      rstn = 1'b0;
      idle_inputs();
      #1;
      check_reset_outputs("midframe reset");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      fd_v = 1'b1; fd_d = W'(32'h99); o_r = 1'b1;
      #1;
      chk("post-rst fd_ready", fd_r, 0);
      chk("post-rst md_ready", md_r, 1);
      fd_v = 1'b0;
      xfer(1'b1, 32'hC0, 1'b0, "post-rst md");
      for (int i = 1; i <= 4; i++) xfer(1'b0, 32'h20 + i, (i == 4), $sformatf("post-rst fd%0d", i));
      chk("post-rst frame_count", fc, fcx(1));

      // Random back-pressure and source gaps over 100 frames
      do_reset();
      mi = 0; fi = 0; oj = 0; nlast = 0; cyc = 0;
      mhs = 1'b0; fhs = 1'b0;
      while (oj < 500 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (mhs) begin md_v = 1'b0; mi++; end
         if (fhs) begin fd_v = 1'b0; fi++; end
         if (!md_v && mi < 100 && $urandom_range(1) == 1) begin md_v = 1'b1; md_d = md_val(mi); end
         if (!fd_v && fi < 400 && $urandom_range(1) == 1) begin fd_v = 1'b1; fd_d = fd_val(fi); end
         o_r = ($urandom_range(1) == 1);
         #1;
         mhs = md_v & md_r;
         fhs = fd_v & fd_r;
         ohs = o_v & o_r;
         if (ohs) begin
            chk($sformatf("rand beat%0d data", oj), o_d, ref_beat(oj));
            chk($sformatf("rand beat%0d last", oj), o_l, (oj % 5 == 4));
            if (o_l) nlast++;
            oj++;
         end
      end
      @(negedge clk);
      idle_inputs();
      chk("rand beats drained", oj, 500);
      chk("rand tlast count", nlast, 100);
      chk("rand frame_count", fc, fcx(100));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mindy_join.md
MINDY_JOIN -- requirements
Module: mindy_join

Interface
REQ-001 SHALL provide parameter DATA_WBITS, default 512, the width of every TDATA bus.
REQ-002 SHALL provide parameter FRAME_BEATS, default 64, the number of frame-data beats per frame; legal range 1 to 65536.
REQ-003 SHALL provide port clk  input  1  the single clock; all logic is rising-edge clocked.
REQ-004 SHALL provide port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide ports AXIS_MD_IN_TDATA/TVALID/TREADY  in/in/out  DATA_WBITS/1/1  meta-data input stream, one beat per frame.
REQ-006 SHALL provide ports AXIS_FD_IN_TDATA/TVALID/TREADY  in/in/out  DATA_WBITS/1/1  frame-data input stream.
REQ-007 SHALL provide ports AXIS_OUT_TDATA/TVALID/TLAST/TREADY  out/out/out/in  DATA_WBITS/1/1/1  joined output stream.
REQ-008 SHALL provide port frame_count  output  32  number of complete frames emitted.

Function
REQ-009 SHALL emit each frame as one meta-data beat followed by exactly FRAME_BEATS frame-data beats, in input order.
REQ-010 SHALL hold output in a single register stage; latency from accepted input beat to AXIS_OUT_TVALID is 1 clock.
REQ-011 SHALL treat the output register as loadable when AXIS_OUT_TVALID=0 or AXIS_OUT_TREADY=1 in the same cycle.
REQ-012 SHALL sustain 1 beat/clock when AXIS_OUT_TREADY is held high and inputs are valid.
REQ-013 SHALL keep AXIS_OUT_TDATA, TLAST and TVALID stable while TVALID=1 and TREADY=0.
REQ-014 SHALL implement two states: S_MD (awaiting meta-data) and S_FD (forwarding frame data).
REQ-015 In S_MD: AXIS_MD_IN_TREADY = loadable; AXIS_FD_IN_TREADY = 0; an MD handshake loads the output with TLAST=0, clears the beat counter, and moves to S_FD.
REQ-016 In S_FD: AXIS_FD_IN_TREADY = loadable; AXIS_MD_IN_TREADY = 0; each FD handshake loads the output and increments the beat counter.
REQ-017 The FD handshake on beat index FRAME_BEATS-1 SHALL set TLAST=1 on that beat, return to S_MD, and increment frame_count.
REQ-018 SHALL size the beat counter to max(1, clog2(FRAME_BEATS)) bits; the counter never exceeds FRAME_BEATS-1.
REQ-019 With FRAME_BEATS=1, every frame SHALL be two beats, with TLAST on the single FD beat.
REQ-020 frame_count SHALL increment when the last beat is loaded into the output register, not when it is drained, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-021 Meta-data presented during S_FD, or frame data presented during S_MD, SHALL be stalled and never dropped.
REQ-022 TREADY outputs SHALL depend combinationally only on state, AXIS_OUT_TVALID and AXIS_OUT_TREADY, never on any input TVALID.

Reset
REQ-023 Assertion of resetn=0 SHALL immediately force AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, state=S_MD, beat counter=0, frame_count=0.
REQ-024 During reset, both input TREADYs SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame, including any undrained output beat; the first accepted beat after reset is meta-data.
REQ-026 resetn deassertion SHALL be synchronous to clk; synchronizing it is the responsibility of the instantiating design.

Configuration
REQ-027 Macro MINDY_JOIN_FRAME_COUNT_EN defined: frame_count SHALL behave per REQ-020.
REQ-028 Macro MINDY_JOIN_FRAME_COUNT_EN undefined: the counter SHALL NOT be implemented and frame_count SHALL be tied to 0; stream behaviour is unchanged.

Verification
(All scenarios: DATA_WBITS=512, FRAME_BEATS=4, MINDY_JOIN_FRAME_COUNT_EN defined.)
REQ-029 SHALL cover this case: MD=0xA0, FD=0x1..0x4, all valid, out TREADY=1 -> out sequence A0,1,2,3,4 on 5 consecutive clocks; TLAST only on 4; frame_count=1.
REQ-030 SHALL cover this case: FD valid before MD -> FD TREADY=0 until the MD handshake; output begins with the MD beat.
REQ-031 SHALL cover this case: out TREADY held 0 for 10 clocks after the first beat -> TDATA=A0 and TVALID=1 held stable; both input TREADYs=0; no beat lost after release.
REQ-032 SHALL cover this case: random 50% out TREADY and input TVALID over 100 frames -> output equals reference interleave; frame_count=100; TLAST count=100.
REQ-033 SHALL cover this case: resetn pulsed low after the 2nd FD beat -> TVALID=0 immediately; frame_count=0; next frame starts with MD and carries 4 full FD beats.
REQ-034 SHALL cover this case: FRAME_BEATS=1 build, 3 frames -> 6 output beats; TLAST on beats 2, 4 and 6.
